// File: rtl/seg_capture_decoder_pkg.sv
// Shared constants for the seven-segment capture path: digit patterns,
// special codes and the capture FSM encoding.
package seg_capture_decoder_pkg;

  // Active-low patterns written g..a (bit 6 = g, bit 0 = a).
  localparam logic [6:0] SEG_PAT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
  };
  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } cap_state_t;

endpackage

// File: rtl/seg_capture_decoder_seg_to_hex.sv
// Combinational seven-segment pattern to hex code decoder.
module seg_to_hex
  import seg_capture_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code
);

  always_comb begin
    code = (seg == SEG_BLANK) ? CODE_BLANK : CODE_ERR;
    for (int i = 0; i < 10; i++)
      if (seg == SEG_PAT[i]) code = 4'(i);
  end

endmodule

// File: rtl/seg_capture_decoder.sv
// Snoops a multiplexed seven-segment bus and captures each digit once its
// anode/pattern pair has been stable for STABLE_CYCLES registered samples.
module seg_capture_decoder
  import seg_capture_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [6:0]                seg,
  input  logic [NUM_DIGITS-1:0]     an,
  output logic [4*NUM_DIGITS-1:0]   digits,
  output logic [NUM_DIGITS-1:0]     digit_valid,
  output logic                      frame_valid,
  output logic                      bad_pattern
);

  localparam int         IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] SC = 8'(STABLE_CYCLES);

  logic [6:0]            seg_r, pat, pat_n;
  logic [NUM_DIGITS-1:0] an_r;
  cap_state_t            state, state_n;
  logic [7:0]            cnt, cnt_n;
  logic [IW-1:0]         idx, idx_n, sidx, acc_idx;
  logic                  sel, same, load, acc, acc_q;
  logic [3:0]            code, acc_code;
  logic [NUM_DIGITS-1:0] dv_base, dv_next;
  int                    nlow;

  seg_to_hex u_dec (.seg(seg_r), .code(code));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r <= SEG_BLANK;
      an_r  <= '1;
    end else begin
      seg_r <= seg;
      an_r  <= an;
    end
  end

  // A sample is usable only when exactly one anode is driven.
  always_comb begin
    nlow = 0;
    sidx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!an_r[i]) begin
        nlow = nlow + 1;
        sidx = IW'(i);
      end
    sel  = (nlow == 1);
    same = sel && (sidx == idx) && (seg_r == pat);
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    pat_n   = pat;
    acc     = 1'b0;
    load    = 1'b0;
    case (state)
      ST_IDLE: load = sel;
      ST_SETTLE:
        if (!sel) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (same) begin
          cnt_n = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
          if (cnt_n >= SC) begin
            acc     = 1'b1;
            state_n = ST_HOLD;
          end
        end else load = 1'b1;
      ST_HOLD:
        if (!same) begin
          if (sel) load = 1'b1;
          else begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end
        end
      default: state_n = ST_IDLE;
    endcase
    // A fresh window; with a one-sample window it is accepted immediately.
    if (load) begin
      idx_n = sidx;
      pat_n = seg_r;
      cnt_n = 8'd1;
      if (SC <= 8'd1) begin
        acc     = 1'b1;
        state_n = ST_HOLD;
      end else state_n = ST_SETTLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      idx      <= '0;
      pat      <= SEG_BLANK;
      acc_q    <= 1'b0;
      acc_idx  <= '0;
      acc_code <= CODE_BLANK;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      pat      <= pat_n;
      acc_q    <= acc;
      acc_idx  <= sidx;
      acc_code <= code;
    end
  end

  // The all-ones valid vector is shown for one cycle alongside frame_valid.
  always_comb begin
    dv_base = frame_valid ? '0 : digit_valid;
    dv_next = dv_base | (acc_q ? (NUM_DIGITS'(1) << acc_idx) : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits      <= {NUM_DIGITS{CODE_BLANK}};
      digit_valid <= '0;
      frame_valid <= 1'b0;
      bad_pattern <= 1'b0;
    end else begin
      digit_valid <= dv_next;
      frame_valid <= acc_q && (&dv_next);
      bad_pattern <= acc_q && (acc_code == CODE_ERR);
      if (acc_q) digits[int'(acc_idx)*4 +: 4] <= acc_code;
    end
  end

endmodule

// File: tb/tb_seg_capture_decoder.sv
// Bench for seg_capture_decoder: directed vector table, latency/reset
// sequences, then random bursts against a run-length reference model.
module tb_seg_capture_decoder;

  localparam int S = 4;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_valid, bad_pattern;

  seg_capture_decoder #(.STABLE_CYCLES(S), .NUM_DIGITS(N)) dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an), .digits(digits),
    .digit_valid(digit_valid), .frame_valid(frame_valid), .bad_pattern(bad_pattern)
  );

  always #5 clk = ~clk;

  logic [6:0] pats [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};
  localparam logic [6:0] BL = 7'b1111111;

  int tests = 0, fails = 0;
  int fcnt = 0, bcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_valid === 1'b1) fcnt++;
    if (bad_pattern === 1'b1) bcnt++;
  end

  // Reference model: counts consecutive identical selectable samples; the
  // run reaching S is an accept, visible two edges after that sample is judged.
  function automatic logic [3:0] ref_decode(input logic [6:0] s);
    ref_decode = (s == BL) ? 4'hF : 4'hE;
    for (int i = 0; i < 10; i++) if (s == pats[i]) ref_decode = 4'(i);
  endfunction

  function automatic int low_count(input logic [3:0] a);
    return $countones(~a);
  endfunction

  function automatic int low_idx(input logic [3:0] a);
    low_idx = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) low_idx = i;
  endfunction

  logic [15:0] m_dig;
  logic [3:0]  m_dv, m_an, l_an, p_c;
  logic        m_fv, m_bad, p_v, was_fv;
  logic [6:0]  m_seg, l_seg;
  int          run, p_i;

  task automatic model_reset();
    m_dig = 16'hFFFF; m_dv = '0; m_fv = 0; m_bad = 0;
    m_seg = BL; m_an = 4'hF; l_seg = BL; l_an = 4'hF;
    run = 0; p_v = 0; p_i = 0; p_c = 4'hF;
  endtask

  task automatic model_step();
    was_fv = m_fv; m_fv = 0; m_bad = 0;
    if (was_fv) m_dv = '0;
    if (p_v) begin
      m_dig[p_i*4 +: 4] = p_c;
      m_dv[p_i] = 1'b1;
      m_fv  = (m_dv == 4'hF);
      m_bad = (p_c == 4'hE);
    end
    p_v = 0;
    if (low_count(m_an) == 1) begin
      if (run > 0 && m_an == l_an && m_seg == l_seg) run = (run < 1000) ? run + 1 : run;
      else run = 1;
      if (run == S) begin
        p_v = 1; p_i = low_idx(m_an); p_c = ref_decode(m_seg);
      end
    end else run = 0;
    l_an = m_an; l_seg = m_seg;
    m_an = an;   m_seg = seg;
  endtask

  always @(posedge clk or posedge rst)
    if (rst) model_reset(); else model_step();

  typedef struct {
    logic [3:0] an; logic [6:0] seg; int n;
    logic [15:0] dig; logic [3:0] dv; int fc; int bc;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] a, logic [6:0] s, int n, logic [15:0] d,
                              logic [3:0] v, int fc, int bc);
    vec_t t;
    t.an = a; t.seg = s; t.n = n; t.dig = d; t.dv = v; t.fc = fc; t.bc = bc;
    return t;
  endfunction

  // Edges after the registering edge until digit_valid[bit] rises.
  task automatic measure(input int bit_i, input logic [3:0] a, input logic [6:0] s,
                         input string name);
    int k;
    an = a; seg = s;
    @(posedge clk); #1;
    k = 0;
    while (k < 20 && digit_valid[bit_i] !== 1'b1) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, k, S + 1);
    @(negedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; an = 4'hF; seg = BL;
    repeat (2) @(negedge clk);
    #1;
    check("reset_digits", digits, 16'hFFFF);
    check("reset_dv", digit_valid, 4'h0);
    check("reset_fv", frame_valid, 1'b0);
    check("reset_bad", bad_pattern, 1'b0);
    rst = 1'b0;
    @(negedge clk); #1;

    measure(0, 4'b1110, pats[2], "latency_d0");
    check("latency_digit", digits, 16'hFFF2);
    check("latency_dv", digit_valid, 4'b0001);

    tbl.push_back(mk(4'b1111, BL,      3,  16'hFFF2, 4'b0001, 0, 0));
    tbl.push_back(mk(4'b1110, pats[1], 7,  16'hFFF1, 4'b0001, 0, 0));
    tbl.push_back(mk(4'b1101, pats[2], 7,  16'hFF21, 4'b0011, 0, 0));
    tbl.push_back(mk(4'b1011, pats[3], 7,  16'hF321, 4'b0111, 0, 0));
    tbl.push_back(mk(4'b0111, pats[4], 7,  16'h4321, 4'b0000, 1, 0));
    tbl.push_back(mk(4'b1100, pats[5], 10, 16'h4321, 4'b0000, 1, 0));
    tbl.push_back(mk(4'b1110, pats[5], 2,  16'h4321, 4'b0000, 1, 0));
    tbl.push_back(mk(4'b1111, BL,      1,  16'h4321, 4'b0000, 1, 0));
    tbl.push_back(mk(4'b1110, pats[5], 3,  16'h4321, 4'b0000, 1, 0));
    tbl.push_back(mk(4'b1111, BL,      4,  16'h4321, 4'b0000, 1, 0));
    tbl.push_back(mk(4'b1110, 7'b0101010, 7, 16'h432E, 4'b0001, 1, 1));
    tbl.push_back(mk(4'b1101, BL,      7,  16'h43FE, 4'b0011, 1, 1));

    foreach (tbl[i]) begin
      an = tbl[i].an; seg = tbl[i].seg;
      repeat (tbl[i].n) @(negedge clk);
      #1;
      check($sformatf("vec%0d_digits", i), digits, tbl[i].dig);
      check($sformatf("vec%0d_dv", i), digit_valid, tbl[i].dv);
      check($sformatf("vec%0d_frames", i), fcnt, tbl[i].fc);
      check($sformatf("vec%0d_bad", i), bcnt, tbl[i].bc);
    end

    // Toggle faster than the stability window: nothing may be captured.
    an = 4'b1110;
    for (int i = 0; i < 12; i++) begin
      seg = ((i / 2) % 2 == 0) ? pats[8] : pats[9];
      @(negedge clk); #1;
    end
    an = 4'hF; seg = BL;
    repeat (3) @(negedge clk);
    #1;
    check("toggle_digits", digits, 16'h43FE);
    check("toggle_dv", digit_valid, 4'b0011);

    // Reset partway through a settle window.
    an = 4'b1101; seg = pats[7];
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_digits", digits, 16'hFFFF);
    check("midrst_dv", digit_valid, 4'h0);
    check("midrst_fv", frame_valid, 1'b0);
    check("midrst_bad", bad_pattern, 1'b0);
    @(negedge clk); #1;
    rst = 1'b0;
    measure(1, 4'b1101, pats[7], "latency_after_rst");
    check("after_rst_digits", digits, 16'hFF7F);

    // Random bursts against the reference model.
    for (int b = 0; b < 80; b++) begin
      int r, sr, n;
      r  = $urandom_range(0, 5);
      sr = $urandom_range(0, 11);
      n  = $urandom_range(1, 7);
      an  = (r < 4) ? ~(4'b0001 << r) : (r == 4) ? 4'hF : 4'($urandom);
      seg = (sr < 10) ? pats[sr] : (sr == 10) ? BL : 7'($urandom);
      if (b == 40) rst = 1'b1;
      for (int c = 0; c < n; c++) begin
        @(negedge clk); #1;
        rst = 1'b0;
        check($sformatf("rand%0d_%0d", b, c), {digits, digit_valid, frame_valid, bad_pattern},
              {m_dig, m_dv, m_fv, m_bad});
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
